// File: rtl/riscv_dmem_responder_if.sv
// Data-memory port between the single-cycle core and its memory responder.
// The core drives address, write data and the two strobes; the responder
// returns combinational read data.
interface riscv_dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_re,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_re,
    output dmem_rdata
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word RAM plus a 16-byte MMIO window holding a
// console TX FIFO, a free-running cycle counter and a tohost halt register.
// MMIO map (offset from MMIO_BASE):
//   +0x0 TXDATA  push wdata[7:0]; reads 0
//   +0x4 STATUS  {16'b0, count[7:0], 5'b0, ovf, empty, full}; write bit2 clears ovf
//   +0x8 CYCLE   read-only cycle counter
//   +0xC TOHOST  first write latches halt/exit_code
module riscv_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  riscv_dmem_responder_if.slave        dmem,
  input  logic                         tx_ready_i,
  output logic                         tx_valid_o,
  output logic [7:0]                   tx_data_o,
  output logic                         halt_o,
  output logic [31:0]                  exit_code_o,
  output logic                         bus_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          halt_q, halt_d;
  logic [31:0]   exit_q, exit_d;
  logic          bus_err_q, bus_err_d;

  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          ram_hit, mmio_hit;
  logic          wr_tx, wr_status, wr_tohost;
  logic          empty, full, pop, push_ok, drop;
  logic [31:0]   status;

  // Address decode; the two low address bits never matter.
  always_comb begin
    ram_idx   = dmem.dmem_addr[AW+1:2];
    reg_sel   = dmem.dmem_addr[3:2];
    ram_hit   = (dmem.dmem_addr >> (AW + 2)) == 32'd0;
    mmio_hit  = dmem.dmem_addr[31:4] == MMIO_BASE[31:4];
    wr_tx     = dmem.dmem_we && mmio_hit && (reg_sel == 2'd0);
    wr_status = dmem.dmem_we && mmio_hit && (reg_sel == 2'd1);
    wr_tohost = dmem.dmem_we && mmio_hit && (reg_sel == 2'd3);
  end

  // FIFO flow control: a push into a full FIFO still fits if the head leaves on the same edge.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = !empty && tx_ready_i;
    push_ok = wr_tx && (!full || pop);
    drop    = wr_tx && !push_ok;
    status  = {16'b0, 8'(count_q), 5'b0, ovf_q, empty, full};
  end

  // Next-state computation for all reset-cleared registers.
  always_comb begin
    rd_ptr_d  = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d   = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    ovf_d     = ovf_q;
    if (drop)                                   ovf_d = 1'b1;
    else if (wr_status && dmem.dmem_wdata[2])   ovf_d = 1'b0;
    cycle_d   = cycle_q + 32'd1;
    halt_d    = halt_q;
    exit_d    = exit_q;
    if (wr_tohost && !halt_q) begin
      halt_d = 1'b1;
      exit_d = dmem.dmem_wdata;
    end
    bus_err_d = bus_err_q
              || ((dmem.dmem_we || dmem.dmem_re) && !ram_hit && !mmio_hit);
  end

  // Control/status registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
      halt_q    <= 1'b0;
      exit_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
      halt_q    <= halt_d;
      exit_q    <= exit_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Storage arrays keep contents across reset; a write on an edge held in reset is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (dmem.dmem_we && ram_hit) mem[ram_idx] <= dmem.dmem_wdata;
      if (push_ok)                 fifo_mem[wr_ptr_q] <= dmem.dmem_wdata[7:0];
    end
  end

  // Combinational read mux; a same-cycle write shows the old value.
  always_comb begin
    dmem.dmem_rdata = '0;
    if (dmem.dmem_re) begin
      if (ram_hit) begin
        dmem.dmem_rdata = mem[ram_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          2'd1:    dmem.dmem_rdata = status;
          2'd2:    dmem.dmem_rdata = cycle_q;
          2'd3:    dmem.dmem_rdata = exit_q;
          default: dmem.dmem_rdata = '0;
        endcase
      end
    end
  end

  assign tx_valid_o  = !empty;
  assign tx_data_o   = empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign halt_o      = halt_q;
  assign exit_code_o = exit_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: directed scenarios followed by random
// traffic, all checked against a queue/array model of the memory map.
module tb_riscv_dmem_responder;
  localparam int          DEPTH_WORDS = 1024;
  localparam int          FIFO_DEPTH  = 8;
  localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        halt;
  logic [31:0] exit_code;
  logic        bus_err;

  riscv_dmem_responder_if bus ();

  riscv_dmem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dmem        (bus),
    .tx_ready_i  (tx_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .halt_o      (halt),
    .exit_code_o (exit_code),
    .bus_err_o   (bus_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m [DEPTH_WORDS];
  logic [7:0]  q_m [$];
  logic        m_ovf, m_halt, m_berr;
  logic [31:0] m_exit, m_cycle;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 = RAM, 1 = MMIO, 2 = unmapped
  function automatic int region(input logic [31:0] a);
    longint unsigned la   = longint'(a);
    longint unsigned base = longint'(MMIO_BASE);
    if (la < longint'(DEPTH_WORDS) * 4) return 0;
    if (la >= base && la < base + 16)   return 1;
    return 2;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic re);
    int off;
    if (!re) return 32'h0;
    case (region(a))
      0: return ram_m[a / 4];
      1: begin
        off = int'((a - MMIO_BASE) / 4);
        case (off)
          1: return (32'(q_m.size()) << 8) | (32'(m_ovf) << 2)
                  | (32'(q_m.size() == 0) << 1) | 32'(q_m.size() == FIFO_DEPTH);
          2: return m_cycle;
          3: return m_exit;
          default: return 32'h0;
        endcase
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    q_m.delete();
    m_ovf = 1'b0; m_halt = 1'b0; m_berr = 1'b0;
    m_exit = 32'h0; m_cycle = 32'h0;
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic do_cycle(input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic re, input logic rdy,
                          output logic [31:0] rd);
    int  rg, off;
    bit  pop, drop;
    bus.dmem_addr  = a;
    bus.dmem_wdata = wd;
    bus.dmem_we    = we;
    bus.dmem_re    = re;
    tx_ready       = rdy;
    #1;
    rd = bus.dmem_rdata;
    chk("rdata",     rd, exp_rdata(a, re));
    chk("tx_valid",  {31'b0, tx_valid}, {31'b0, q_m.size() != 0});
    chk("tx_data",   {24'b0, tx_data}, {24'b0, (q_m.size() != 0) ? q_m[0] : 8'h00});
    chk("halt",      {31'b0, halt}, {31'b0, m_halt});
    chk("exit_code", exit_code, m_exit);
    chk("bus_err",   {31'b0, bus_err}, {31'b0, m_berr});
    @(posedge clk);
    rg   = region(a);
    off  = (rg == 1) ? int'((a - MMIO_BASE) / 4) : -1;
    pop  = (q_m.size() != 0) && rdy;
    drop = 1'b0;
    if (pop) void'(q_m.pop_front());
    if (we && off == 0) begin
      if (q_m.size() < FIFO_DEPTH) q_m.push_back(wd[7:0]);
      else drop = 1'b1;
    end
    if (drop)                         m_ovf = 1'b1;
    else if (we && off == 1 && wd[2]) m_ovf = 1'b0;
    m_cycle = m_cycle + 32'd1;
    if (we && off == 3 && !m_halt) begin
      m_halt = 1'b1;
      m_exit = wd;
    end
    if (we && rg == 0)          ram_m[a / 4] = wd;
    if ((we || re) && rg == 2)  m_berr = 1'b1;
    @(negedge clk);
  endtask

  // Assert reset between edges, check the immediate clear, release at a falling edge.
  task automatic reset_mid();
    rst_n          = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;
    bus.dmem_we    = 1'b0;
    bus.dmem_re    = 1'b0;
    tx_ready       = 1'b0;
    #1;
    chk("rst_halt",     {31'b0, halt}, 32'h0);
    chk("rst_exit",     exit_code, 32'h0);
    chk("rst_bus_err",  {31'b0, bus_err}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data",  {24'b0, tx_data}, 32'h0);
    chk("rst_rdata",    bus.dmem_rdata, 32'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [7:0]  drain_exp [FIFO_DEPTH];

    bus.dmem_addr = 32'h0; bus.dmem_wdata = 32'h0;
    bus.dmem_we = 1'b0;    bus.dmem_re = 1'b0;
    model_clear();
    @(negedge clk);
    reset_mid();

    // Reset status and cycle counter at cycle 5
    do_cycle(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("status_reset", rd, 32'h0000_0002);
    repeat (4) do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    do_cycle(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("cycle5", rd, 32'd5);

    // Preload the RAM region used by the bench
    for (int i = 0; i < 64; i++)
      do_cycle(32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0, rd);

    // RAM word access, byte offsets ignored
    do_cycle(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, rd);
    do_cycle(32'h40, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("ram_40", rd, 32'hDEAD_BEEF);
    do_cycle(32'h43, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("ram_43", rd, 32'hDEAD_BEEF);
    do_cycle(32'h44, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    do_cycle(32'h40, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    chk("ram_re0", rd, 32'h0);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 8; i++)
      do_cycle(MMIO_BASE, 32'(8'h41 + i), 1'b1, 1'b0, 1'b0, rd);
    do_cycle(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("status_full", rd, 32'h0000_0801);
    do_cycle(MMIO_BASE, 32'h49, 1'b1, 1'b0, 1'b0, rd);
    do_cycle(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("status_ovf", rd, 32'h0000_0805);
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", {24'b0, tx_data}, 32'(8'h41 + i));
      do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd);
    end
    chk("drain_empty", {31'b0, tx_valid}, 32'h0);
    do_cycle(MMIO_BASE + 32'h4, 32'h4, 1'b1, 1'b0, 1'b0, rd);
    do_cycle(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("status_ovf_clr", rd, 32'h0000_0002);

    // Push into a full FIFO while the head pops
    for (int i = 0; i < 8; i++)
      do_cycle(MMIO_BASE, 32'(8'h51 + i), 1'b1, 1'b0, 1'b0, rd);
    do_cycle(MMIO_BASE, 32'h5A, 1'b1, 1'b0, 1'b1, rd);
    do_cycle(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("status_full_pop", rd, 32'h0000_0801);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'(8'h52 + i);
    drain_exp[7] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      chk("full_pop_byte", {24'b0, tx_data}, {24'b0, drain_exp[i]});
      do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd);
    end
    chk("full_pop_empty", {31'b0, tx_valid}, 32'h0);

    // Cycle counter wrap
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    do_cycle(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("cycle_max", rd, 32'hFFFF_FFFF);
    do_cycle(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("cycle_wrap", rd, 32'h0);

    // TOHOST first write wins
    do_cycle(MMIO_BASE + 32'hC, 32'h1, 1'b1, 1'b0, 1'b0, rd);
    chk("halt_set", {31'b0, halt}, 32'h1);
    chk("exit_first", exit_code, 32'h1);
    do_cycle(MMIO_BASE + 32'hC, 32'h7, 1'b1, 1'b0, 1'b0, rd);
    chk("exit_kept", exit_code, 32'h1);
    do_cycle(MMIO_BASE + 32'hC, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("tohost_read", rd, 32'h1);

    // Unmapped access sets sticky bus_err and leaves RAM alone
    do_cycle(32'h2000_0000, 32'h1234_5678, 1'b1, 1'b1, 1'b0, rd);
    chk("unmapped_rdata", rd, 32'h0);
    chk("bus_err_set", {31'b0, bus_err}, 32'h1);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("bus_err_sticky", {31'b0, bus_err}, 32'h1);

    // Mid-program reset keeps RAM
    reset_mid();
    do_cycle(32'h40, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("ram_retained", rd, 32'hDEAD_BEEF);
    do_cycle(MMIO_BASE + 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    chk("mmio_end_rdata", rd, 32'h0);
    chk("mmio_end_bus_err", {31'b0, bus_err}, 32'h1);

    // Random traffic against the model
    for (int r = 0; r < 2; r++) begin
      reset_mid();
      for (int n = 0; n < 300; n++) begin
        case ($urandom_range(0, 39))
          0:       a = ($urandom_range(0, 1) == 0) ? 32'h2000_0000 + 32'($urandom_range(0, 255))
                                                   : MMIO_BASE + 32'h10 + 32'($urandom_range(0, 15));
          1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18,19,20:
                   a = 32'($urandom_range(0, 255));
          default: a = MMIO_BASE + 32'($urandom_range(0, 15));
        endcase
        do_cycle(a, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder for the single-cycle RV32E core: it terminates the core's data-memory port (address, write data, read data, write enable, read enable). It combines a word-addressed RAM with a small MMIO window. The window holds a buffered console transmit FIFO, a free-running cycle counter and a tohost halt register. It sits beside the core in the simulation top and gives test programs a console and an exit path.

## Interface
- DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two, ≥ 2)
- FIFO_DEPTH, 8, console TX FIFO entries (power of two, ≥ 2)
- MMIO_BASE, 32'h1000_0000, base byte address of the MMIO window (16-byte aligned)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- dmem_addr  input  32  byte address from core
- dmem_wdata  input  32  write data from core
- dmem_we  input  1  write request, committed at clock edge
- dmem_re  input  1  read request
- dmem_rdata  output  32  read data, combinational from address
- tx_valid  output  1  console byte available
- tx_data  output  8  console byte at FIFO head
- tx_ready  input  1  console sink accepts byte
- halt  output  1  program has written TOHOST
- exit_code  output  32  value written to TOHOST
- bus_err  output  1  sticky: access outside RAM and MMIO window

## Operation
- Decode, using byte addresses. dmem_addr[1:0] is ignored everywhere.
  - RAM: addr < DEPTH_WORDS*4.
  - MMIO: MMIO_BASE ≤ addr < MMIO_BASE+16.
  - Anything else is unmapped.
- RAM
  - Read is asynchronous: rdata = mem[addr[log2(DEPTH_WORDS)+1:2]].
  - Write is a full word, synchronous, and occurs when we=1.
  - RAM contents are not cleared by reset.
- MMIO register map
  - +0x0 TXDATA
    - Write pushes wdata[7:0] into the FIFO.
    - The push is accepted if count < FIFO_DEPTH, or if a pop happens on the same edge.
    - Otherwise the byte is dropped and OVF is set.
    - Reads return 0.
  - +0x4 STATUS
    - Read returns {16'b0, count[7:0], 5'b0, OVF, empty, full}.
    - A write with wdata[2]=1 clears OVF.
    - If a write clears OVF on the same edge that another drop sets it, the set wins.
  - +0x8 CYCLE
    - Read-only 32-bit counter, +1 every cycle out of reset, wraps from 0xFFFF_FFFF to 0.
    - A read returns the pre-increment value for that cycle.
  - +0xC TOHOST
    - The first write sets halt=1 and exit_code=wdata.
    - Later writes are ignored while halt=1; only reset clears halt.
    - Reads return exit_code.
- Unmapped addresses
  - Reads return 0; writes are dropped.
  - Any access (re or we) sets bus_err. Only reset clears bus_err.
- dmem_rdata is 0 whenever re=0.
  - With re=1 and we=1 on the same address, rdata shows the pre-write value; the write commits at the edge.
- Console FIFO
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH, plus count (0..FIFO_DEPTH).
  - tx_valid = (count≠0); tx_data = head entry, or 0 when empty.
  - A pop occurs on an edge with tx_valid && tx_ready.
  - Simultaneous push and pop leaves count unchanged.
- halt does not block RAM, FIFO or counter activity; the FIFO keeps draining after halt.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0, halt=0, exit_code=0, bus_err=0.
  - OVF=0, count=0, pointers=0, CYCLE=0.
  - dmem_rdata follows the combinational decode (0 with re=0).
- Reset asserted mid-operation clears all state immediately except RAM. A write in progress on that edge is lost.
- Read latency is 0 cycles, so the single-cycle core samples rdata in the same cycle it drives the address.
- Write, push, pop and STATUS updates are visible to reads in the cycle after the edge.
- tx_valid rises the cycle after the first push into an empty FIFO.
  - No push-to-pop bypass: an empty FIFO with push and tx_ready high in the same cycle produces no pop.
- halt and exit_code update on the edge of the first TOHOST write.
- bus_err rises on the edge of the offending access.

## Test plan
- RAM: write 0xDEADBEEF to 0x40, then read 0x40 and 0x43 → both return 0xDEADBEEF. Read 0x44 with we=0 returns the preloaded value. Read with re=0 → rdata=0.
- FIFO fill/drain with tx_ready=0:
  - Push 0x41..0x48 → STATUS=0x0000_0801.
  - Ninth push 0x49 → dropped, STATUS=0x0000_0805.
  - Raise tx_ready → bytes 0x41..0x48 emerge on 8 consecutive cycles, then tx_valid=0.
  - Write 0x4 to STATUS → OVF=0.
- Full FIFO with tx_ready=1, push 0x5A → accepted, count stays 8, and 0x5A is the last byte out.
- CYCLE: release reset and read +0x8 on cycle 5 → 5. Force the counter to 0xFFFF_FFFF → next read returns 0.
- TOHOST:
  - Write 0x1, then 0x7 → halt=1 with exit_code=1 after the first edge and unchanged after the second.
  - Assert rst low mid-program → halt=0, exit_code=0 immediately, with RAM data retained.
- Access to 0x2000_0000, and to MMIO_BASE+0x10 → rdata=0 and bus_err=1 on the next cycle, remaining set. RAM is unchanged.
